// File: rtl/bram_col_ctrl_pkg.sv
// bram_col_ctrl_pkg: shared definitions for the rotating BRAM column-buffer sequencer.
// Holds the controller state encoding, the window size K derived from the BRAM count,
// and the modulo-NB_MEM index increment used for memory-role rotation.
package bram_col_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Convolver window size: all memories but the spare one are read together.
   function automatic int unsigned k_of(input int unsigned nb_mem);
      return nb_mem - 1;
   endfunction

   // Advance a memory index, wrapping at nb_mem.
   function automatic int unsigned mem_inc(input int unsigned idx, input int unsigned nb_mem);
      return (idx + 1 >= nb_mem) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/bram_col_ctrl_col_counter.sv
// bram_col_ctrl_col_counter: column address counter, one per side of the buffer.
// Ports: i_clk/i_rst (sync, active high), i_clr, i_inc, i_len (column length),
//        o_cnt (current address), o_end (WRAP=1: at len-1, wraps on inc; WRAP=0: reached len, holds).
module bram_col_ctrl_col_counter #(
   parameter int unsigned NB_ADDRESS = 10,
   parameter bit          WRAP       = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   input  logic                  i_inc,
   input  logic [NB_ADDRESS-1:0] i_len,
   output logic [NB_ADDRESS-1:0] o_cnt,
   output logic                  o_end
);

   logic [NB_ADDRESS-1:0] cnt_q;
   logic [NB_ADDRESS-1:0] cnt_d;

   // Write side flags the last address of a column; read side flags that the
   // whole column has been issued and parks there until cleared.
   assign o_end = WRAP ? (cnt_q == (i_len - NB_ADDRESS'(1))) : (cnt_q == i_len);
   assign o_cnt = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_inc) begin
         if (WRAP && o_end) begin
            cnt_d = '0;
         end else if (!(!WRAP && o_end)) begin
            cnt_d = cnt_q + NB_ADDRESS'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bram_col_ctrl.sv
// bram_col_ctrl: sequencer for NB_MEM BRAMs used as rotating column buffers of a KxK convolver (K = NB_MEM-1).
// Ports: loader stream (i_ld_valid/i_ld_data/o_ld_ready), BRAM write side (o_wr_en/o_wr_addr/o_wr_data),
//        convolver read side (i_rd_en, o_rd_addr, o_mem_sel, o_rd_valid), control (i_start, i_col_len, i_num_cols, o_busy, o_done).
// Optional: define BRAM_COL_CTRL_STALL_CNT_EN to add o_stall_cnt (saturating count of RUN cycles waiting on the writer).
module bram_col_ctrl
   import bram_col_ctrl_pkg::*;
#(
   parameter int unsigned NB_ADDRESS = 10,
   parameter int unsigned RAM_WIDTH  = 13,
   parameter int unsigned NB_MEM     = 4,
   parameter int unsigned NB_COLS    = 10
) (
   input  logic                      i_CLK,
   input  logic                      i_rst,
   input  logic                      i_start,
   input  logic [NB_ADDRESS-1:0]     i_col_len,
   input  logic [NB_COLS-1:0]        i_num_cols,
   input  logic                      i_ld_valid,
   input  logic [RAM_WIDTH-1:0]      i_ld_data,
   output logic                      o_ld_ready,
   input  logic                      i_rd_en,
   output logic [NB_MEM-1:0]         o_wr_en,
   output logic [NB_ADDRESS-1:0]     o_wr_addr,
   output logic [RAM_WIDTH-1:0]      o_wr_data,
   output logic [NB_ADDRESS-1:0]     o_rd_addr,
   output logic [$clog2(NB_MEM)-1:0] o_mem_sel,
   output logic                      o_rd_valid,
`ifdef BRAM_COL_CTRL_STALL_CNT_EN
   output logic [15:0]               o_stall_cnt,
`endif
   output logic                      o_busy,
   output logic                      o_done
);

   localparam int unsigned        K      = k_of(NB_MEM);
   localparam int unsigned        MW     = $clog2(NB_MEM);
   localparam logic [NB_COLS-1:0] K_COLS = NB_COLS'(K);

   state_e                  state_q;
   logic [NB_ADDRESS-1:0]   col_len_q;
   logic [NB_COLS-1:0]      num_cols_q;
   logic [MW-1:0]           wr_mem_q;
   logic [MW-1:0]           mem_sel_q;
   logic [NB_COLS-1:0]      loaded_q;
   logic [NB_COLS-1:0]      out_q;
   logic                    col_wr_done_q;
   logic [NB_ADDRESS-1:0]   rd_addr_q;
   logic                    rd_valid_q;

   logic                    start_ok;
   logic                    wr_fire;
   logic                    wr_last;
   logic                    wr_col_end;
   logic [NB_ADDRESS-1:0]   wr_cnt;
   logic                    rd_issue;
   logic                    rd_full;
   logic [NB_ADDRESS-1:0]   rd_cnt;
   logic                    wr_side_ready;
   logic                    rotate;
   logic                    last_out;
   logic                    ld_ready;

   assign start_ok   = (state_q == ST_IDLE) && i_start && (i_col_len != '0) && (i_num_cols >= K_COLS);
   assign wr_fire    = i_ld_valid && ld_ready;
   assign wr_col_end = wr_fire && wr_last;
   assign rd_issue   = (state_q == ST_RUN) && i_rd_en && !rd_full;

   // The spare memory is free to rotate once its column is complete, or
   // immediately when the image has no columns left to load.
   assign wr_side_ready = col_wr_done_q || (loaded_q == num_cols_q);
   // Waiting for rd_valid to drop keeps the last beat tied to the current mem_sel.
   assign rotate   = (state_q == ST_RUN) && rd_full && wr_side_ready && !rd_valid_q;
   assign last_out = ((out_q + NB_COLS'(1)) == (num_cols_q - K_COLS + NB_COLS'(1)));

   always_comb begin
      ld_ready = 1'b0;
      case (state_q)
         ST_FILL: ld_ready = 1'b1;
         ST_RUN:  ld_ready = !col_wr_done_q && (loaded_q < num_cols_q);
         default: ld_ready = 1'b0;
      endcase
   end

   bram_col_ctrl_col_counter #(.NB_ADDRESS(NB_ADDRESS), .WRAP(1'b1)) u_wr_cnt (
      .i_clk (i_CLK),
      .i_rst (i_rst),
      .i_clr (start_ok),
      .i_inc (wr_fire),
      .i_len (col_len_q),
      .o_cnt (wr_cnt),
      .o_end (wr_last)
   );

   bram_col_ctrl_col_counter #(.NB_ADDRESS(NB_ADDRESS), .WRAP(1'b0)) u_rd_cnt (
      .i_clk (i_CLK),
      .i_rst (i_rst),
      .i_clr (start_ok || rotate),
      .i_inc (rd_issue),
      .i_len (col_len_q),
      .o_cnt (rd_cnt),
      .o_end (rd_full)
   );

   always_ff @(posedge i_CLK) begin
      if (i_rst) begin
         state_q       <= ST_IDLE;
         col_len_q     <= '0;
         num_cols_q    <= '0;
         wr_mem_q      <= '0;
         mem_sel_q     <= '0;
         loaded_q      <= '0;
         out_q         <= '0;
         col_wr_done_q <= 1'b0;
         rd_addr_q     <= '0;
         rd_valid_q    <= 1'b0;
      end else begin
         rd_valid_q <= rd_issue;
         if (rd_issue) begin
            rd_addr_q <= rd_cnt;
         end
         case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  state_q       <= ST_FILL;
                  col_len_q     <= i_col_len;
                  num_cols_q    <= i_num_cols;
                  wr_mem_q      <= '0;
                  mem_sel_q     <= '0;
                  loaded_q      <= '0;
                  out_q         <= '0;
                  col_wr_done_q <= 1'b0;
               end
            end
            ST_FILL: begin
               if (wr_col_end) begin
                  loaded_q <= loaded_q + NB_COLS'(1);
                  if ((loaded_q + NB_COLS'(1)) == K_COLS) begin
                     state_q  <= ST_RUN;
                     wr_mem_q <= MW'(K);
                  end else begin
                     wr_mem_q <= MW'(mem_inc(32'(wr_mem_q), NB_MEM));
                  end
               end
            end
            ST_RUN: begin
               // rotate requires the column already written, so it never
               // coincides with wr_col_end.
               if (wr_col_end) begin
                  loaded_q      <= loaded_q + NB_COLS'(1);
                  col_wr_done_q <= 1'b1;
               end
               if (rotate) begin
                  out_q <= out_q + NB_COLS'(1);
                  if (last_out) begin
                     state_q <= ST_DONE;
                  end else begin
                     mem_sel_q     <= MW'(mem_inc(32'(mem_sel_q), NB_MEM));
                     wr_mem_q      <= MW'(mem_inc(32'(wr_mem_q), NB_MEM));
                     col_wr_done_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef BRAM_COL_CTRL_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge i_CLK) begin
      if (i_rst || start_ok) begin
         stall_q <= '0;
      end else if ((state_q == ST_RUN) && rd_full && !wr_side_ready && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign o_stall_cnt = stall_q;
`endif

   assign o_ld_ready = ld_ready;
   assign o_wr_en    = wr_fire ? ({{(NB_MEM-1){1'b0}}, 1'b1} << wr_mem_q) : '0;
   assign o_wr_addr  = wr_cnt;
   assign o_wr_data  = i_ld_data;
   assign o_rd_addr  = rd_addr_q;
   assign o_mem_sel  = mem_sel_q;
   assign o_rd_valid = rd_valid_q;
   assign o_busy     = (state_q != ST_IDLE);
   assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_bram_col_ctrl.sv
// tb_bram_col_ctrl: randomized bench for bram_col_ctrl against a column-level model.
// The model tracks which image column each BRAM location holds and the expected
// write/read sequence of an image; every observed beat is checked against it.
module tb_bram_col_ctrl;

   localparam int NA = 10;
   localparam int RW = 13;
   localparam int NM = 4;
   localparam int NC = 10;
   localparam int K  = NM - 1;
   localparam int MW = $clog2(NM);
   localparam int NO_STALL = 1 << 30;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          start;
   logic [NA-1:0] col_len;
   logic [NC-1:0] num_cols;
   logic          ld_valid;
   logic [RW-1:0] ld_data;
   logic          ld_ready;
   logic          rd_en;
   logic [NM-1:0] wr_en;
   logic [NA-1:0] wr_addr;
   logic [RW-1:0] wr_data;
   logic [NA-1:0] rd_addr;
   logic [MW-1:0] mem_sel;
   logic          rd_valid;
   logic          busy;
   logic          done;
`ifdef BRAM_COL_CTRL_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   bram_col_ctrl #(.NB_ADDRESS(NA), .RAM_WIDTH(RW), .NB_MEM(NM), .NB_COLS(NC)) dut (
      .i_CLK      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_col_len  (col_len),
      .i_num_cols (num_cols),
      .i_ld_valid (ld_valid),
      .i_ld_data  (ld_data),
      .o_ld_ready (ld_ready),
      .i_rd_en    (rd_en),
      .o_wr_en    (wr_en),
      .o_wr_addr  (wr_addr),
      .o_wr_data  (wr_data),
      .o_rd_addr  (rd_addr),
      .o_mem_sel  (mem_sel),
      .o_rd_valid (rd_valid),
`ifdef BRAM_COL_CTRL_STALL_CNT_EN
      .o_stall_cnt(stall_cnt),
`endif
      .o_busy     (busy),
      .o_done     (done)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [RW-1:0] pix [0:4095];
   int            tag_m [NM][1024];

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One full image: writes must land column c -> memory c%NM at addresses 0..L-1,
   // output column j must read mem_sel j%NM with all K window columns resident.
   task automatic run_op(input int L, input int N, input int p_ld, input int p_rd,
                         input int ss, input int sl);
      int acc;
      int rd;
      int cyc;
      int j;
      bit done_seen;
      for (int i = 0; i < N * L; i++) pix[i] = RW'($urandom);
      for (int m = 0; m < NM; m++)
         for (int a = 0; a < 1024; a++) tag_m[m][a] = -1;
      @(posedge clk); #1;
      start = 1'b1; col_len = NA'(L); num_cols = NC'(N);
      acc = 0; rd = 0; cyc = 0; done_seen = 1'b0;
      while (!done_seen && cyc < 3000) begin
         @(posedge clk); #1;
         start    = 1'b0;
         ld_valid = (acc < N * L) && !(cyc >= ss && cyc < ss + sl) && ($urandom_range(99) < p_ld);
         ld_data  = ld_valid ? pix[acc] : RW'($urandom);
         rd_en    = ($urandom_range(99) < p_rd);
         @(negedge clk);
         chk("wr_gate", longint'(|wr_en), longint'(ld_valid && ld_ready));
         if (acc == N * L) chk("ready_after_last", ld_ready, 0);
         if (|wr_en) begin
            j = acc / L;
            chk("wr_extra", acc < N * L, 1);
            chk("wr_en", wr_en, 1 << (j % NM));
            chk("wr_addr", wr_addr, acc % L);
            chk("wr_data", wr_data, pix[acc]);
            tag_m[j % NM][acc % L] = j;
            acc++;
         end
         if (rd_valid) begin
            j = rd / L;
            chk("rd_extra", rd < (N - K + 1) * L, 1);
            chk("rd_addr", rd_addr, rd % L);
            chk("mem_sel", mem_sel, j % NM);
            for (int m = 0; m < K; m++)
               chk("rd_window", tag_m[(int'(mem_sel) + m) % NM][rd_addr], j + m);
            rd++;
         end
         if (done) done_seen = 1'b1;
         cyc++;
      end
      chk("timeout", done_seen, 1);
      chk("wr_total", acc, N * L);
      chk("rd_total", rd, (N - K + 1) * L);
      @(posedge clk); #1;
      ld_valid = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_single", done, 0);
   endtask

   task automatic bad_start(input int L, input int N);
      @(posedge clk); #1;
      start = 1'b1; col_len = NA'(L); num_cols = NC'(N); ld_valid = 1'b1; rd_en = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         chk("bad_busy", busy, 0);
         chk("bad_wr_en", wr_en, 0);
      end
      ld_valid = 1'b0; rd_en = 1'b0;
   endtask

   task automatic reset_mid_run();
      @(posedge clk); #1;
      start = 1'b1; col_len = NA'(4); num_cols = NC'(5);
      repeat (20) begin
         @(posedge clk); #1;
         start = 1'b0; ld_valid = 1'b1; ld_data = RW'($urandom); rd_en = 1'b1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; ld_valid = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_mem_sel", mem_sel, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; col_len = '0; num_cols = '0;
      ld_valid = 1'b0; ld_data = '0; rd_en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("init_ld_ready", ld_ready, 0);
      chk("init_wr_en", wr_en, 0);
      chk("init_rd_addr", rd_addr, 0);
      chk("init_mem_sel", mem_sel, 0);
      chk("init_rd_valid", rd_valid, 0);
      chk("init_busy", busy, 0);
      chk("init_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Continuous stream with a 6-cycle loader gap early in RUN.
      run_op(4, 5, 100, 100, 14, 6);
`ifdef BRAM_COL_CTRL_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, 6);
`endif
      run_op(4, 5, 100, 100, NO_STALL, 0);

      bad_start(0, 5);
      bad_start(4, 2);

      reset_mid_run();
      run_op(4, 5, 100, 100, NO_STALL, 0);

      // Boundary shapes: single-pixel columns and the minimum image width.
      run_op(1, K, 100, 100, NO_STALL, 0);
      run_op(1, K + 3, 60, 60, NO_STALL, 0);

      for (int t = 0; t < 10; t++) begin
         run_op($urandom_range(1, 6), $urandom_range(K, K + 4),
                $urandom_range(30, 100), $urandom_range(30, 100), NO_STALL, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
